// File: rtl/bram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM between two requesters.
// Commands are registered onto the BRAM port; read data is routed back via a tag line.
module bram_rr_arbiter #(
  parameter int unsigned AW     = 9,
  parameter int unsigned DW     = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clock,
  input  logic          reset,

  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_data,

  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_data,

  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wen,
  input  logic [DW-1:0] mem_rdata,

  output logic          busy
);

  // One stage for the BRAM input register plus RD_LAT stages of BRAM latency.
  localparam int unsigned TagDepth = RD_LAT + 1;

  logic          last_grant_q, last_grant_d;
  logic          grant_valid;
  logic          grant_id;

  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_wen_q, mem_wen_d;

  logic [TagDepth-1:0] tag_vld_q, tag_vld_d;
  logic [TagDepth-1:0] tag_id_q, tag_id_d;

  logic          rsp_fire;
  logic          rsp_id;
  logic          rsp0_valid_q, rsp0_valid_d;
  logic          rsp1_valid_q, rsp1_valid_d;
  logic [DW-1:0] rsp0_data_q, rsp0_data_d;
  logic [DW-1:0] rsp1_data_q, rsp1_data_d;

  // Grant: on contention the requester that did not win last time goes first.
  always_comb begin
    grant_valid = req0_valid | req1_valid;
    grant_id    = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant_q;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
    last_grant_d = grant_valid ? grant_id : last_grant_q;
  end

  assign req0_ready = grant_valid & ~grant_id;
  assign req1_ready = grant_valid & grant_id;

  always_comb begin
    sel_we    = req0_we;
    sel_addr  = req0_addr;
    sel_wdata = req0_wdata;
    if (grant_id) begin
      sel_we    = req1_we;
      sel_addr  = req1_addr;
      sel_wdata = req1_wdata;
    end
  end

  // BRAM port: address and data hold when idle so the port stays quiet.
  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wen_d   = 1'b0;
    if (grant_valid) begin
      mem_addr_d  = sel_addr;
      mem_wdata_d = sel_wdata;
      mem_wen_d   = sel_we;
    end
  end

  always_comb begin
    tag_vld_d = (tag_vld_q << 1) | TagDepth'(grant_valid & ~sel_we);
    tag_id_d  = (tag_id_q << 1) | TagDepth'(grant_id);
  end

  assign rsp_fire = tag_vld_q[TagDepth-1];
  assign rsp_id   = tag_id_q[TagDepth-1];

  always_comb begin
    rsp0_valid_d = rsp_fire & ~rsp_id;
    rsp1_valid_d = rsp_fire & rsp_id;
    rsp0_data_d  = rsp0_valid_d ? mem_rdata : rsp0_data_q;
    rsp1_data_d  = rsp1_valid_d ? mem_rdata : rsp1_data_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wen_q    <= 1'b0;
      tag_vld_q    <= '0;
      tag_id_q     <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wen_q    <= mem_wen_d;
      tag_vld_q    <= tag_vld_d;
      tag_id_q     <= tag_id_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wen    = mem_wen_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_data  = rsp1_data_q;
  assign busy       = |tag_vld_q;

endmodule

// File: tb/tb_bram_rr_arbiter.sv
// Directed bench for bram_rr_arbiter with a behavioural 512x32 BRAM (RD_LAT = 1).
module tb_bram_rr_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req0_valid = 1'b0, req0_we = 1'b0;
  logic [8:0]  req0_addr = '0;
  logic [31:0] req0_wdata = '0;
  logic        req1_valid = 1'b0, req1_we = 1'b0;
  logic [8:0]  req1_addr = '0;
  logic [31:0] req1_wdata = '0;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_data, rsp1_data;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wen;
  logic [31:0] mem_rdata;
  logic        busy;

  logic        bram_init = 1'b0;
  logic [31:0] bram [512];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  bram_rr_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_we    (req0_we),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .rsp0_valid (rsp0_valid),
    .rsp0_data  (rsp0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_we    (req1_we),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .rsp1_valid (rsp1_valid),
    .rsp1_data  (rsp1_data),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wen    (mem_wen),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  // Read-first single-port BRAM; contents preset to 0xC0DE0000 + address.
  always @(posedge clock) begin
    if (bram_init) begin
      for (int i = 0; i < 512; i++) bram[i] <= 32'hC0DE_0000 + 32'(i);
    end else if (mem_wen) begin
      bram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= bram[mem_addr];
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_we = 1'b0;
    req1_valid = 1'b0; req1_we = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b1;
    bram_init = 1'b1;
    step();
    step();
    @(negedge clock);
    reset = 1'b0;
    bram_init = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    bram_init = 1'b1;
    step();
    step();
    @(negedge clock);
    checks++;
    if ({mem_wen, mem_addr, mem_wdata} !== 42'd0) begin
      errors++;
      $display("FAIL reset_mem: got wen=%b addr=%h wdata=%h expected all zero",
               mem_wen, mem_addr, mem_wdata);
    end
    checks++;
    if ({rsp0_valid, rsp1_valid, rsp0_data, rsp1_data, busy} !== 67'd0) begin
      errors++;
      $display("FAIL reset_rsp: got v0=%b v1=%b d0=%h d1=%h busy=%b expected all zero",
               rsp0_valid, rsp1_valid, rsp0_data, rsp1_data, busy);
    end
    reset = 1'b0;
    bram_init = 1'b0;
  endtask

  task automatic test_write_read();
    for (int c = 0; c < 6; c++) begin
      step();
      idle_inputs();
      if (c == 0) begin
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 9'h005; req0_wdata = 32'h15;
      end else if (c == 1) begin
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 9'h005;
      end
      @(negedge clock);
      if (c <= 1) begin
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
          errors++;
          $display("FAIL wr_rd_ready c%0d: got %b expected 10", c, {req0_ready, req1_ready});
        end
      end
      if (c == 1) begin
        checks++;
        if ({mem_wen, mem_addr, mem_wdata} !== {1'b1, 9'h005, 32'h15}) begin
          errors++;
          $display("FAIL wr_port: got wen=%b addr=%h data=%h expected 1 005 00000015",
                   mem_wen, mem_addr, mem_wdata);
        end
      end
      if (c == 2) begin
        checks++;
        if ({mem_wen, busy} !== 2'b01) begin
          errors++;
          $display("FAIL rd_port: got wen=%b busy=%b expected 0 1", mem_wen, busy);
        end
      end
      if (c == 3 || c == 5) begin
        checks++;
        if (rsp0_valid !== 1'b0) begin
          errors++;
          $display("FAIL wr_rd_early c%0d: got rsp0_valid=%b expected 0", c, rsp0_valid);
        end
      end
      if (c == 4) begin
        checks++;
        if ({rsp0_valid, rsp0_data} !== {1'b1, 32'h15}) begin
          errors++;
          $display("FAIL wr_rd_data: got v=%b d=%h expected 1 00000015", rsp0_valid, rsp0_data);
        end
      end
      checks++;
      if (rsp1_valid !== 1'b0) begin
        errors++;
        $display("FAIL wr_rd_rsp1 c%0d: got %b expected 0", c, rsp1_valid);
      end
    end
  endtask

  task automatic test_contention();
    apply_reset();
    for (int c = 0; c < 11; c++) begin
      step();
      idle_inputs();
      if (c < 8) begin
        req0_valid = 1'b1; req0_addr = 9'h010;
        req1_valid = 1'b1; req1_addr = 9'h020;
      end
      @(negedge clock);
      if (c < 8) begin
        checks++;
        if ({req0_ready, req1_ready} !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL rr_ready c%0d: got %b", c, {req0_ready, req1_ready});
        end
      end
      if (c >= 3) begin
        checks++;
        if ((c - 3) % 2 == 0) begin
          if ({rsp0_valid, rsp1_valid, rsp0_data} !== {2'b10, 32'hC0DE_0010}) begin
            errors++;
            $display("FAIL rr_rsp c%0d: got v=%b%b d0=%h expected 10 c0de0010",
                     c, rsp0_valid, rsp1_valid, rsp0_data);
          end
        end else begin
          if ({rsp0_valid, rsp1_valid, rsp1_data} !== {2'b01, 32'hC0DE_0020}) begin
            errors++;
            $display("FAIL rr_rsp c%0d: got v=%b%b d1=%h expected 01 c0de0020",
                     c, rsp0_valid, rsp1_valid, rsp1_data);
          end
        end
      end
    end
  endtask

  task automatic test_single_req1();
    int pulses = 0;
    for (int c = 0; c < 9; c++) begin
      step();
      idle_inputs();
      if (c < 5) begin
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 9'h030 + 9'(c);
      end
      @(negedge clock);
      if (c < 5) begin
        checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
          errors++;
          $display("FAIL solo_ready c%0d: got %b expected 01", c, {req0_ready, req1_ready});
        end
      end
      if (c >= 1 && c <= 5) begin
        checks++;
        if ({mem_wen, mem_addr} !== {1'b0, 9'h030 + 9'(c - 1)}) begin
          errors++;
          $display("FAIL solo_port c%0d: got wen=%b addr=%h", c, mem_wen, mem_addr);
        end
      end
      if (rsp1_valid === 1'b1) begin
        pulses++;
        checks++;
        if (rsp1_data !== 32'hC0DE_0030 + 32'(c - 3)) begin
          errors++;
          $display("FAIL solo_data c%0d: got %h expected %h", c, rsp1_data,
                   32'hC0DE_0030 + 32'(c - 3));
        end
      end
      checks++;
      if (rsp0_valid !== 1'b0) begin
        errors++;
        $display("FAIL solo_rsp0 c%0d: got %b expected 0", c, rsp0_valid);
      end
    end
    checks++;
    if (pulses != 5) begin
      errors++;
      $display("FAIL solo_pulses: got %0d expected 5", pulses);
    end
  endtask

  task automatic test_full_range();
    for (int c = 0; c < 8; c++) begin
      step();
      idle_inputs();
      case (c)
        0: begin req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 9'h1FF; req0_wdata = 32'hDEADBEEF; end
        1: begin req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 9'h000; req0_wdata = 32'h10; end
        2: begin req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 9'h1FF; end
        3: begin req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 9'h000; end
        default: ;
      endcase
      @(negedge clock);
      if (c == 5) begin
        checks++;
        if ({rsp0_valid, rsp0_data} !== {1'b1, 32'hDEADBEEF}) begin
          errors++;
          $display("FAIL range_1ff: got v=%b d=%h expected 1 deadbeef", rsp0_valid, rsp0_data);
        end
      end
      if (c == 6) begin
        checks++;
        if ({rsp0_valid, rsp0_data} !== {1'b1, 32'h10}) begin
          errors++;
          $display("FAIL range_000: got v=%b d=%h expected 1 00000010", rsp0_valid, rsp0_data);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    for (int c = 0; c < 3; c++) begin
      step();
      idle_inputs();
      if (c == 0) begin
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 9'h040;
      end else if (c == 1) begin
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 9'h041; req0_wdata = 32'h41;
      end
      @(negedge clock);
    end
    checks++;
    if ({mem_wen, busy} !== 2'b11) begin
      errors++;
      $display("FAIL midrst_pre: got wen=%b busy=%b expected 1 1", mem_wen, busy);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({mem_wen, busy} !== 2'b00) begin
      errors++;
      $display("FAIL midrst_async: got wen=%b busy=%b expected 0 0", mem_wen, busy);
    end
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      @(negedge clock);
      checks++;
      if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin
        errors++;
        $display("FAIL midrst_quiet c%0d: got v=%b%b busy=%b expected 000",
                 c, rsp0_valid, rsp1_valid, busy);
      end
    end
    step();
    req0_valid = 1'b1; req0_addr = 9'h000;
    req1_valid = 1'b1; req1_addr = 9'h001;
    @(negedge clock);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL midrst_first_grant: got %b expected 10", {req0_ready, req1_ready});
    end
    step();
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      step();
    end
  endtask

  task automatic test_idle_hold();
    for (int c = 0; c < 6; c++) begin
      step();
      idle_inputs();
      if (c == 0) begin
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 9'h055;
      end
      @(negedge clock);
      if (c >= 1) begin
        checks++;
        if ({mem_wen, mem_addr, busy} !== {1'b0, 9'h055, (c <= 2)}) begin
          errors++;
          $display("FAIL idle_hold c%0d: got wen=%b addr=%h busy=%b", c, mem_wen, mem_addr, busy);
        end
      end
      if (c >= 3) begin
        checks++;
        if ({rsp0_valid, rsp0_data} !== {(c == 3), 32'hC0DE_0055}) begin
          errors++;
          $display("FAIL idle_rsp c%0d: got v=%b d=%h", c, rsp0_valid, rsp0_data);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_contention();
    test_single_req1();
    test_full_range();
    test_reset_midflight();
    test_idle_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
